// File: rtl/pipeline_ctrl.sv
// Pipeline hazard/flush/halt controller: stage stalls and clears are combinational from FSM state and inputs, and the FSM and counters update on the next edge.
// Backpressure: dmem busy stalls every stage and freezes all state except the stall counter.
module pipeline_ctrl #(
    parameter int FLUSH_CYCLES = 2,
    parameter int DRAIN_CYCLES = 4,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             aresetn,
    input  logic             i_mem_hazard,
    input  logic             i_branch_taken,
    input  logic             i_dmem_busy,
    input  logic             i_halt_req,
    input  logic             i_resume,
    input  logic             i_cnt_clr,
    output logic             o_if_stall,
    output logic             o_id_stall,
    output logic             o_ex_stall,
    output logic             o_me_stall,
    output logic             o_id_clr,
    output logic             o_ex_clr,
    output logic             o_halted,
    output logic [CNT_W-1:0] o_stall_cnt,
    output logic [CNT_W-1:0] o_flush_cnt
);

    typedef enum logic [1:0] {RUN, FLUSH, HALTING, HALTED} state_t;

    localparam logic [2:0]       FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);
    localparam logic [3:0]       DRAIN_LOAD = 4'(DRAIN_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;

    state_t     state_q;
    logic [2:0] flush_left_q;
    logic [3:0] drain_left_q;
    logic       halt_pend_q;
    logic       br_acc;
    logic       halt_eff;
    logic       stall_inc;

    assign br_acc    = i_branch_taken && !i_dmem_busy && (state_q == RUN || state_q == FLUSH);
    assign halt_eff  = i_halt_req || halt_pend_q;
    assign stall_inc = o_if_stall && (state_q == RUN || state_q == FLUSH);

    always_comb begin
        o_if_stall = 1'b0;
        o_id_stall = 1'b0;
        o_ex_stall = 1'b0;
        o_me_stall = 1'b0;
        o_id_clr   = 1'b0;
        o_ex_clr   = 1'b0;
        o_halted   = 1'b0;
        if (state_q == HALTED) begin
            o_if_stall = 1'b1;
            o_id_stall = 1'b1;
            o_ex_stall = 1'b1;
            o_me_stall = 1'b1;
            o_halted   = 1'b1;
        end else if (i_dmem_busy) begin
            o_if_stall = 1'b1;
            o_id_stall = 1'b1;
            o_ex_stall = 1'b1;
            o_me_stall = 1'b1;
        end else if (state_q == HALTING) begin
            // Draining: fetch frozen, bubbles fed into ID; a late branch still squashes EX.
            o_if_stall = 1'b1;
            o_id_clr   = 1'b1;
            o_ex_clr   = i_branch_taken;
        end else if (i_branch_taken) begin
            o_id_clr = 1'b1;
            o_ex_clr = 1'b1;
        end else if (state_q == FLUSH) begin
            o_id_clr = 1'b1;
        end else if (i_mem_hazard) begin
            o_if_stall = 1'b1;
            o_id_stall = 1'b1;
            o_ex_clr   = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state_q      <= RUN;
            flush_left_q <= '0;
            drain_left_q <= '0;
            halt_pend_q  <= 1'b0;
        end else begin
            case (state_q)
                RUN: begin
                    if (i_dmem_busy) begin
                        if (i_halt_req) halt_pend_q <= 1'b1;
                    end else if (i_branch_taken) begin
                        if (FLUSH_CYCLES > 1) begin
                            state_q      <= FLUSH;
                            flush_left_q <= FLUSH_LOAD;
                            halt_pend_q  <= halt_eff;
                        end else if (halt_eff) begin
                            state_q      <= HALTING;
                            drain_left_q <= DRAIN_LOAD;
                            halt_pend_q  <= 1'b0;
                        end
                    end else if (halt_eff) begin
                        state_q      <= HALTING;
                        drain_left_q <= DRAIN_LOAD;
                        halt_pend_q  <= 1'b0;
                    end
                end
                FLUSH: begin
                    if (i_dmem_busy) begin
                        if (i_halt_req) halt_pend_q <= 1'b1;
                    end else if (i_branch_taken) begin
                        flush_left_q <= FLUSH_LOAD;
                        if (i_halt_req) halt_pend_q <= 1'b1;
                    end else if (flush_left_q == 3'd1) begin
                        flush_left_q <= '0;
                        if (halt_eff) begin
                            state_q      <= HALTING;
                            drain_left_q <= DRAIN_LOAD;
                            halt_pend_q  <= 1'b0;
                        end else begin
                            state_q <= RUN;
                        end
                    end else begin
                        flush_left_q <= flush_left_q - 3'd1;
                        if (i_halt_req) halt_pend_q <= 1'b1;
                    end
                end
                HALTING: begin
                    if (!i_dmem_busy) begin
                        if (drain_left_q == 4'd1) begin
                            drain_left_q <= '0;
                            state_q      <= HALTED;
                        end else begin
                            drain_left_q <= drain_left_q - 4'd1;
                        end
                    end
                end
                HALTED: begin
                    if (i_resume) state_q <= RUN;
                end
                default: state_q <= RUN;
            endcase
        end
    end

    // Clear wins over increment; both counters stick at all-ones.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            o_stall_cnt <= '0;
            o_flush_cnt <= '0;
        end else if (i_cnt_clr) begin
            o_stall_cnt <= '0;
            o_flush_cnt <= '0;
        end else begin
            if (stall_inc && o_stall_cnt != CNT_MAX) o_stall_cnt <= o_stall_cnt + 1'b1;
            if (br_acc && o_flush_cnt != CNT_MAX)    o_flush_cnt <= o_flush_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: expected control vectors are queued as each cycle is driven and checked mid-cycle.
module tb_pipeline_ctrl;

    localparam int CW = 4;

    // {if_stall, id_stall, ex_stall, me_stall, id_clr, ex_clr, halted}
    localparam logic [6:0] E_IDLE    = 7'b0000000;
    localparam logic [6:0] E_HAZ     = 7'b1100010;
    localparam logic [6:0] E_BUSY    = 7'b1111000;
    localparam logic [6:0] E_BR      = 7'b0000110;
    localparam logic [6:0] E_FL      = 7'b0000100;
    localparam logic [6:0] E_HING    = 7'b1000100;
    localparam logic [6:0] E_HING_BR = 7'b1000110;
    localparam logic [6:0] E_HALTED  = 7'b1111001;

    logic          clk = 1'b0;
    logic          aresetn;
    logic          i_mem_hazard, i_branch_taken, i_dmem_busy, i_halt_req, i_resume, i_cnt_clr;
    logic          o_if_stall, o_id_stall, o_ex_stall, o_me_stall, o_id_clr, o_ex_clr, o_halted;
    logic [CW-1:0] o_stall_cnt, o_flush_cnt;

    int tests = 0;
    int fails = 0;

    logic [6:0] sb_q[$];
    string      tag_q[$];

    pipeline_ctrl #(.FLUSH_CYCLES(2), .DRAIN_CYCLES(4), .CNT_W(CW)) dut (
        .clk            (clk),
        .aresetn        (aresetn),
        .i_mem_hazard   (i_mem_hazard),
        .i_branch_taken (i_branch_taken),
        .i_dmem_busy    (i_dmem_busy),
        .i_halt_req     (i_halt_req),
        .i_resume       (i_resume),
        .i_cnt_clr      (i_cnt_clr),
        .o_if_stall     (o_if_stall),
        .o_id_stall     (o_id_stall),
        .o_ex_stall     (o_ex_stall),
        .o_me_stall     (o_me_stall),
        .o_id_clr       (o_id_clr),
        .o_ex_clr       (o_ex_clr),
        .o_halted       (o_halted),
        .o_stall_cnt    (o_stall_cnt),
        .o_flush_cnt    (o_flush_cnt)
    );

    always #5 clk = ~clk;

    task automatic check_out();
        logic [6:0] obs;
        logic [6:0] exp_v;
        string      tag;
        obs   = {o_if_stall, o_id_stall, o_ex_stall, o_me_stall, o_id_clr, o_ex_clr, o_halted};
        exp_v = sb_q.pop_front();
        tag   = tag_q.pop_front();
        tests++;
        assert (obs === exp_v) else begin
            fails++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp_v);
        end
    endtask

    task automatic chk_cnt(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp_v);
        tests++;
        assert (obs === exp_v) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    // One clock cycle: drive inputs just after the rising edge, check at the falling edge.
    task automatic cyc(input logic hz, input logic br, input logic busy, input logic hr,
                       input logic rs, input logic clr, input logic [6:0] exp_v, input string tag);
        i_mem_hazard   = hz;
        i_branch_taken = br;
        i_dmem_busy    = busy;
        i_halt_req     = hr;
        i_resume       = rs;
        i_cnt_clr      = clr;
        sb_q.push_back(exp_v);
        tag_q.push_back(tag);
        @(negedge clk);
        check_out();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        aresetn = 1'b0;
        i_mem_hazard = 1'b0; i_branch_taken = 1'b0; i_dmem_busy = 1'b0;
        i_halt_req = 1'b0; i_resume = 1'b0; i_cnt_clr = 1'b0;
        @(posedge clk); #1;

        cyc(0,0,0,0,0,0, E_IDLE, "in_reset_idle");
        chk_cnt("in_reset_stall_cnt", o_stall_cnt, 4'd0);
        chk_cnt("in_reset_flush_cnt", o_flush_cnt, 4'd0);
        @(negedge clk); aresetn = 1'b1;
        @(posedge clk); #1;
        cyc(0,0,0,0,0,0, E_IDLE, "post_reset_idle");

        // Load-use hazard for one cycle.
        cyc(1,0,0,0,0,0, E_HAZ, "hazard");
        chk_cnt("hazard_stall_cnt", o_stall_cnt, 4'd1);
        cyc(0,0,0,0,0,0, E_IDLE, "hazard_after");

        // Single taken branch: two ID clears, one EX clear.
        cyc(0,1,0,0,0,0, E_BR, "branch_c0");
        cyc(0,0,0,0,0,0, E_FL, "branch_c1");
        cyc(0,0,0,0,0,0, E_IDLE, "branch_c2");
        chk_cnt("branch_flush_cnt", o_flush_cnt, 4'd1);
        chk_cnt("branch_stall_cnt", o_stall_cnt, 4'd1);

        // Branch held back by busy memory for three cycles.
        cyc(0,0,0,0,0,1, E_IDLE, "clr");
        chk_cnt("clr_stall_cnt", o_stall_cnt, 4'd0);
        chk_cnt("clr_flush_cnt", o_flush_cnt, 4'd0);
        for (int k = 0; k < 3; k++) cyc(0,1,1,0,0,0, E_BUSY, "busy_branch");
        chk_cnt("busy_branch_no_accept", o_flush_cnt, 4'd0);
        cyc(0,1,0,0,0,0, E_BR, "busy_branch_accept");
        chk_cnt("busy_branch_stall_cnt", o_stall_cnt, 4'd3);
        chk_cnt("busy_branch_flush_cnt", o_flush_cnt, 4'd1);
        cyc(0,0,0,0,0,0, E_FL, "busy_branch_fl");
        cyc(0,0,0,0,0,0, E_IDLE, "busy_branch_run");

        // Hazard ignored during FLUSH.
        cyc(0,1,0,0,0,0, E_BR, "fl_haz_br");
        cyc(1,0,0,0,0,0, E_FL, "fl_haz_ignored");
        cyc(0,0,0,0,0,0, E_IDLE, "fl_haz_run");

        // Busy inside FLUSH freezes the flush countdown.
        cyc(0,1,0,0,0,0, E_BR, "fl_busy_br");
        cyc(0,0,1,0,0,0, E_BUSY, "fl_busy");
        cyc(0,0,0,0,0,0, E_FL, "fl_busy_resume");
        cyc(0,0,0,0,0,0, E_IDLE, "fl_busy_run");
        chk_cnt("fl_busy_stall_cnt", o_stall_cnt, 4'd4);

        // Halt requested in FLUSH, taken on FLUSH exit, then four drain cycles.
        cyc(0,1,0,0,0,0, E_BR, "halt_fl_br");
        cyc(0,0,0,1,0,0, E_FL, "halt_fl_req");
        cyc(0,0,0,0,0,0, E_HING, "halting_d4");
        cyc(0,1,0,0,0,0, E_HING_BR, "halting_d3_branch");
        cyc(0,0,1,0,0,0, E_BUSY, "halting_busy_hold");
        cyc(1,0,0,0,0,0, E_HING, "halting_d2_hazard");
        cyc(0,0,0,0,0,0, E_HING, "halting_d1");
        cyc(0,0,0,0,0,0, E_HALTED, "halted");
        cyc(1,1,1,1,0,0, E_HALTED, "halted_ignores");
        chk_cnt("halt_flush_cnt", o_flush_cnt, 4'd4);
        chk_cnt("halt_stall_cnt", o_stall_cnt, 4'd4);
        cyc(0,0,0,0,1,0, E_HALTED, "resume_cycle");
        cyc(0,0,0,0,0,0, E_IDLE, "resumed");

        // Halt from RUN, then resume and halt_req together: resume wins.
        cyc(0,0,0,1,0,0, E_IDLE, "run_halt_req");
        for (int k = 0; k < 4; k++) cyc(0,0,0,0,0,0, E_HING, "run_halting");
        cyc(0,0,0,0,0,0, E_HALTED, "run_halted");
        cyc(0,0,0,1,1,0, E_HALTED, "resume_and_halt");
        cyc(0,0,0,0,0,0, E_IDLE, "resume_wins");

        // Stall counter saturation and clear-over-increment.
        cyc(0,0,0,0,0,1, E_IDLE, "sat_clr");
        for (int k = 0; k < 20; k++) cyc(0,0,1,0,0,0, E_BUSY, "sat_busy");
        chk_cnt("sat_stall_cnt", o_stall_cnt, 4'd15);
        cyc(0,0,1,0,0,1, E_BUSY, "sat_clr_busy");
        chk_cnt("sat_clr_stall_cnt", o_stall_cnt, 4'd0);
        cyc(0,0,0,0,0,0, E_IDLE, "sat_done");

        // Asynchronous reset in the middle of HALTING.
        cyc(0,1,0,0,0,0, E_BR, "pre_rst_branch");
        cyc(0,0,0,0,0,0, E_FL, "pre_rst_fl");
        cyc(0,0,0,1,0,0, E_IDLE, "rst_halt_req");
        cyc(0,0,0,0,0,0, E_HING, "rst_halting_a");
        cyc(0,0,0,0,0,0, E_HING, "rst_halting_b");
        aresetn = 1'b0;
        #2;
        sb_q.push_back(E_IDLE);
        tag_q.push_back("rst_mid_halting");
        check_out();
        chk_cnt("rst_mid_flush_cnt", o_flush_cnt, 4'd0);
        @(negedge clk); aresetn = 1'b1;
        @(posedge clk); #1;
        cyc(0,0,0,0,0,0, E_IDLE, "post_rst_idle");
        cyc(0,1,0,0,0,0, E_BR, "post_rst_branch");
        cyc(0,0,0,0,0,0, E_FL, "post_rst_fl");
        cyc(0,0,0,0,0,0, E_IDLE, "post_rst_run");
        chk_cnt("post_rst_flush_cnt", o_flush_cnt, 4'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 Parameter FLUSH_CYCLES, default 2, meaning cycles o_id_clr is held per taken branch (range 1..7).
REQ-002 Parameter DRAIN_CYCLES, default 4, meaning bubble cycles injected before halt completes (range 1..15).
REQ-003 Parameter CNT_W, default 32, meaning performance counter width.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 aresetn  input  1  asynchronous, active-low reset.
REQ-006 i_mem_hazard  input  1  load-use hazard detected in ID.
REQ-007 i_branch_taken  input  1  branch/jump resolved taken in EX.
REQ-008 i_dmem_busy  input  1  data memory not ready; ME cannot complete.
REQ-009 i_halt_req  input  1  single-cycle halt request.
REQ-010 i_resume  input  1  single-cycle resume request.
REQ-011 i_cnt_clr  input  1  synchronous clear of both counters.
REQ-012 o_if_stall, o_id_stall, o_ex_stall, o_me_stall  output  1 each  hold the corresponding stage register.
REQ-013 o_id_clr, o_ex_clr  output  1 each  synchronous clear (bubble) of ID/EX stage register.
REQ-014 o_halted  output  1  pipeline halted.
REQ-015 o_stall_cnt  output  CNT_W  cycles with o_if_stall=1 while in RUN or FLUSH.
REQ-016 o_flush_cnt  output  CNT_W  number of accepted taken branches.

Function
REQ-017 FSM states SHALL be RUN, FLUSH, HALTING, HALTED; control outputs are combinational from state and inputs.
REQ-018 Priority each cycle SHALL be: HALTED > i_dmem_busy > i_branch_taken > i_mem_hazard > normal.
REQ-019 i_dmem_busy=1 (not HALTED): all four stall outputs =1, both clears =0, no state or counter advance except o_stall_cnt; a coincident branch is not accepted that cycle.
REQ-020 Branch accepted (i_branch_taken=1, i_dmem_busy=0, not HALTED): o_id_clr=1, o_ex_clr=1, stalls =0, o_flush_cnt+1; if FLUSH_CYCLES>1 enter FLUSH with counter=FLUSH_CYCLES-1.
REQ-021 FLUSH: o_id_clr=1 each non-busy cycle, counter decrements; at counter 1 return to RUN (or HALTING if halt pending); a new accepted branch reloads the counter.
REQ-022 Load-use (i_mem_hazard=1, no branch, no busy, RUN): o_if_stall=1, o_id_stall=1, o_ex_clr=1, o_ex_stall=0, o_me_stall=0; i_mem_hazard ignored in FLUSH, HALTING.
REQ-023 i_halt_req in RUN: enter HALTING with drain counter=DRAIN_CYCLES; in FLUSH: set halt-pending, taken on FLUSH exit; in HALTING/HALTED: ignored.
REQ-024 HALTING: o_if_stall=1, o_id_clr=1; branches still clear EX; drain counter decrements on non-busy cycles; at 1 go to HALTED.
REQ-025 HALTED: all stalls =1, clears =0, o_halted=1; i_resume returns to RUN next edge, all other inputs ignored.
REQ-026 i_resume outside HALTED SHALL be ignored; simultaneous halt_req and resume in HALTED -> resume wins.
REQ-027 Counters SHALL saturate at all-ones; i_cnt_clr zeroes them and overrides increment that cycle.
REQ-028 o_stall_cnt increments on cycles with o_if_stall=1 in RUN or FLUSH only.

Reset
REQ-029 aresetn=0 SHALL immediately force state RUN, halt-pending=0, flush/drain counters=0, o_stall_cnt=0, o_flush_cnt=0.
REQ-030 During and after reset in RUN with inputs 0, all stall and clear outputs =0 and o_halted=0.
REQ-031 Reset asserted mid-FLUSH/HALTING/HALTED SHALL abandon the operation with no residual pending halt.

Verification
REQ-032 i_mem_hazard=1 one cycle in RUN -> o_if_stall=o_id_stall=o_ex_clr=1 that cycle, o_stall_cnt=1.
REQ-033 i_branch_taken pulse, FLUSH_CYCLES=2 -> o_id_clr=1 for 2 consecutive cycles, o_ex_clr=1 first cycle, o_flush_cnt=1.
REQ-034 i_branch_taken and i_dmem_busy both 1 for 3 cycles, then busy=0 -> all stalls 3 cycles, branch accepted on 4th cycle, o_stall_cnt=3.
REQ-035 i_halt_req during FLUSH -> HALTING after FLUSH, o_halted=1 after DRAIN_CYCLES=4 more cycles; i_resume -> o_halted=0 next cycle.
REQ-036 o_stall_cnt preloaded near all-ones by continuous busy (CNT_W=4, 20 busy cycles) -> holds at 15; i_cnt_clr -> 0.
REQ-037 aresetn pulled low mid-HALTING -> outputs at reset values immediately; after release a branch gives normal FLUSH behaviour.
